uart_txrx_core: RTL and testbench
=================================

Name: uart_txrx_core

Overview:
- Full-duplex 8N1 UART core: one transmitter and one receiver sharing a clock and reset; the two paths are independent.
- Provides a byte-level start/busy interface for TX and a data/valid interface for RX.
- Sits between a host-side register/FIFO layer and the device pins.
- Supports pin-level loopback (tx wired to rx) for self-test.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per bit period (baud = f_clk / CLKS_PER_BIT). Legal range is 4 or more; baud counters must be wide enough for CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data_in  in  8  byte to transmit; sampled on the cycle tx_start is accepted.
- tx_start  in  1  request to transmit; level-sampled each cycle.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high while a TX frame is in progress.
- rx  in  1  serial input; asynchronous to clk.
- rx_data_out  out  8  last correctly framed received byte.
- rx_valid  out  1  one-cycle pulse when rx_data_out is updated.

Behaviour:
- Reset (async assert, sync release) values:
  - tx=1, tx_busy=0, TX FSM=IDLE.
  - rx_data_out=8'h00, rx_valid=0, RX FSM=IDLE, synchronizer flops=1.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_start=1 at a rising edge, latch tx_data_in into a shift register, set tx_busy=1 and go to START. tx drives 0 from that edge onward (registered output).
  - START: holds for CLKS_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: tx = latched bit[index] for CLKS_PER_BIT cycles. index 0..7; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and clear tx_busy.
  - tx_busy is high for exactly 10*CLKS_PER_BIT cycles.
  - tx_start while busy is ignored; no queuing.
  - tx_start still high on the first IDLE cycle after a frame starts a new frame back-to-back.
  - Changing tx_data_in mid-frame has no effect.
- RX input path: rx passes through a 2-flop synchronizer. All RX decisions use the synchronized signal, which adds 2 cycles of latency.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for synchronized rx=0, then go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 (mid-bit), re-sample.
    - If rx=0: the start bit is valid; go to DATA with counter reset.
    - If rx=1: the low level was a glitch; return to IDLE with no output change.
  - DATA: every CLKS_PER_BIT cycles (bit centre), shift the sample into bit[index], LSB first. After 8 bits, go to STOP.
  - STOP: sample at the stop-bit centre.
    - If rx=1: rx_data_out <= assembled byte and rx_valid=1 for exactly one cycle.
    - If rx=0 (framing error): discard the byte; rx_data_out keeps its previous value; no rx_valid.
    - In both cases return to IDLE immediately after the mid-stop sample, so back-to-back frames are received.
- rx_data_out holds its value indefinitely until the next valid frame.
- rx_valid is low at all other times.
- Loopback latency: from tx_start accepted to rx_valid is about 9.5*CLKS_PER_BIT + 3 cycles, always less than 10*CLKS_PER_BIT + 50 cycles.
- Reset mid-frame: both FSMs return to IDLE at once and all outputs take their reset values. A partial RX frame is discarded.
- TX and RX are fully independent; simultaneous activity on both is legal.

Test Plan:
- Loopback (tx tied to rx), CLKS_PER_BIT=100, 1 MHz clock: reset 2 us, idle 2 us, send 0xAA (one-cycle tx_start). Required: rx_data_out=0xAA by 1050 us later, one rx_valid pulse, tx_busy high for exactly 1000 cycles.
- Same setup, three further frames sent in sequence: 0x55, 0xFF, 0x00, each spaced by 10 us. Required: rx_data_out equals each byte after its frame, and the 0xFF to 0x00 transition proves the data register updates.
- Waveform check on tx for 0x55: low 100 cycles, then bits 1,0,1,0,1,0,1,0 at 100 cycles each, high 100 cycles, and tx_busy drops on the same edge tx returns to IDLE.
- tx_start pulsed again at mid-frame with different data: no effect; frame and busy timing unchanged.
- Glitch and framing checks:
  - Drive rx low for 20 cycles: no frame received.
  - Drive a frame with stop bit = 0: no rx_valid, rx_data_out unchanged.
- Assert rst_n mid-frame on both paths: tx=1, tx_busy=0, rx_data_out=0x00, rx_valid=0 immediately. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_txrx_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing clk/rst_n.
// TX drives registered serial output; RX samples a 2-flop synchronized input at bit centres.
module uart_txrx_core #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_in,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data_out,
  output logic       rx_valid
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_n, tx_busy_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx       <= tx_n;
      tx_busy  <= tx_busy_n;
    end
  end

  // tx is registered, so each bit value is computed one state ahead of the line.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_n       = tx;
    tx_busy_n  = tx_busy;
    case (tx_state)
      IDLE: begin
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
        if (tx_start) begin
          tx_state_n = START;
          tx_sh_n    = tx_data_in;
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
          tx_busy_n  = 1'b1;
        end
      end
      START: begin
        if (tx_cnt == LAST) begin
          tx_state_n = DATA;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_n       = tx_sh[0];
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_state_n = STOP;
            tx_n       = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 1'b1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            tx_n     = tx_sh[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == LAST) begin
          tx_state_n = IDLE;
          tx_cnt_n   = '0;
          tx_busy_n  = 1'b0;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n;
  logic          rx_s1, rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_state    <= IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_sh       <= '0;
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_idx      <= rx_idx_n;
      rx_sh       <= rx_sh_n;
      rx_data_out <= rx_data_n;
      rx_valid    <= rx_valid_n;
    end
  end

  // After the half-bit start check the counter is reset, so every LAST lands on a bit centre.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data_out;
    rx_valid_n = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_s2) begin
          rx_state_n = START;
          rx_cnt_n   = '0;
        end
      end
      START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s2 ? IDLE : DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_idx_n = rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state_n = STOP;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt == LAST) begin
          rx_state_n = IDLE;
          rx_cnt_n   = '0;
          if (rx_s2) begin
            rx_data_n  = rx_sh;
            rx_valid_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed bench for uart_txrx_core: table-driven loopback frames plus
// glitch, framing-error and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_txrx_core;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data_in;
  logic       tx_start;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       loop;
  logic       rx_drv;

  assign rx = loop ? tx : rx_drv;

  uart_txrx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data_in(tx_data_in),
    .tx_start(tx_start),
    .tx(tx),
    .tx_busy(tx_busy),
    .rx(rx),
    .rx_data_out(rx_data_out),
    .rx_valid(rx_valid)
  );

  always #500 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // frame: bit k is the expected tx level during bit slot k (start, d0..d7, stop)
  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;
    logic [7:0] exp_rx;
    bit         poke;
  } vec_t;

  vec_t vecs[6];

  task automatic send_frame(input vec_t v);
    int         busy_cnt = 0;
    int         pulses = 0;
    logic [7:0] got = 8'h00;
    logic [9:0] bad = '0;
    @(negedge clk);
    tx_data_in = v.din;
    tx_start   = 1'b1;
    for (int k = 0; k < 1050; k++) begin
      @(negedge clk);
      if (k < 1000 && tx !== v.frame[k / CPB]) bad[k / CPB] = 1'b1;
      if (tx_busy) busy_cnt++;
      if (k == 1000) check($sformatf("busy_drop_%0h", v.din), {30'd0, tx_busy, tx}, 32'd1);
      if (rx_valid) begin
        pulses++;
        got = rx_data_out;
      end
      if (k == 0) tx_start = 1'b0;
      if (v.poke && k == 500) begin
        tx_data_in = ~v.din;
        tx_start   = 1'b1;
      end
      if (v.poke && k == 501) tx_start = 1'b0;
    end
    for (int i = 0; i < 10; i++)
      check($sformatf("tx_%0h_slot%0d", v.din, i), {31'd0, bad[i]}, 32'd0);
    check($sformatf("busy_cycles_%0h", v.din), busy_cnt, 1000);
    check($sformatf("valid_pulses_%0h", v.din), pulses, 1);
    check($sformatf("valid_data_%0h", v.din), {24'd0, got}, {24'd0, v.exp_rx});
    check($sformatf("rx_hold_%0h", v.din), {24'd0, rx_data_out}, {24'd0, v.exp_rx});
    repeat (10) @(negedge clk);
  endtask

  task automatic drive_rx_frame(input logic [7:0] data, input logic stop, output int pulses);
    logic [9:0] bits;
    bits   = {stop, data, 1'b0};
    pulses = 0;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (rx_valid) pulses++;
        rx_drv = bits[s];
      end
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
      rx_drv = 1'b1;
    end
  endtask

  initial begin
    int pulses;
    vecs[0] = '{8'hAA, 10'b1101010100, 8'hAA, 1'b0};
    vecs[1] = '{8'h55, 10'b1010101010, 8'h55, 1'b1};
    vecs[2] = '{8'hFF, 10'b1111111110, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 10'b1000000000, 8'h00, 1'b0};
    vecs[4] = '{8'h3C, 10'b1001111000, 8'h3C, 1'b0};
    vecs[5] = '{8'h5A, 10'b1010110100, 8'h5A, 1'b0};

    rst_n      = 1'b0;
    loop       = 1'b1;
    rx_drv     = 1'b1;
    tx_start   = 1'b0;
    tx_data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data_out}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) send_frame(vecs[i]);

    // short low pulse on rx must be rejected by the mid-start check
    loop   = 1'b0;
    rx_drv = 1'b1;
    @(negedge clk);
    pulses = 0;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk) if (rx_valid) pulses++;
    rx_drv = 1'b1;
    repeat (200) @(negedge clk) if (rx_valid) pulses++;
    check("glitch_pulses", pulses, 0);
    check("glitch_data", {24'd0, rx_data_out}, 32'h3C);

    drive_rx_frame(8'hC3, 1'b0, pulses);
    check("framing_pulses", pulses, 0);
    check("framing_data", {24'd0, rx_data_out}, 32'h3C);

    // reset in the middle of a loopback frame
    loop = 1'b1;
    @(negedge clk);
    tx_data_in = 8'hA5;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (400) @(negedge clk);
    check("mid_busy_before_reset", {31'd0, tx_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_reset_rx_data", {24'd0, rx_data_out}, 32'd0);
    check("mid_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
